id_hazard_scoreboard: RTL and testbench

Parametrised successor to the decode-stage hazard logic. It tracks in-flight register writers in its own scoreboard, so the EXE/MEM destination inputs are no longer needed. Each decode cycle it either issues the instruction, stalls it, or squashes it. In forwarding mode it also selects a forwarding source per operand and stalls only on load-use. Sits in the ID stage between the control unit and the ID/EXE pipeline register.

---
 rtl/id_hazard_pkg.sv | 31 +++
 rtl/wb_scoreboard.sv | 42 ++++
 rtl/id_hazard_scoreboard.sv | 116 +++++++++++
 tb/tb_id_hazard_scoreboard.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/id_hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : id_hazard_pkg
// Purpose  : Shared slot type, constants and match predicate for the ID-stage
//            hazard scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
package id_hazard_pkg;

    // Slot dest field is sized for the widest supported register address.
    localparam int c_SB_ADDR_W     = 8;
    localparam int FWD_SEL_REGFILE = 0;

    typedef struct packed {
        logic                   valid;
        logic [c_SB_ADDR_W-1:0] dest;
        logic                   wb_en;
        logic                   load;
    } sb_slot_t;

    function automatic logic sb_match(
        input sb_slot_t               slot,
        input logic [c_SB_ADDR_W-1:0] src,
        input logic                   src_used
    );
        return slot.valid && slot.wb_en && src_used &&
               (slot.dest == src) && (src != '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : wb_scoreboard
// Purpose  : Shift register of in-flight writer slots, slot 0 = youngest.
// Revision : 1.0 - initial release
// ============================================================================
module wb_scoreboard
    import id_hazard_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  sb_slot_t                         shift_in,
    output logic [DEPTH*$bits(sb_slot_t)-1:0] slots_flat
);

    localparam int c_SLOT_W = $bits(sb_slot_t);

    sb_slot_t r_slots [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_slots[k] <= '0;
            end
        end else begin
            r_slots[0] <= shift_in;
            for (int k = 1; k < DEPTH; k++) begin
                r_slots[k] <= r_slots[k-1];
            end
        end
    end

    generate
        for (genvar k = 0; k < DEPTH; k++) begin : g_flat
            assign slots_flat[k*c_SLOT_W +: c_SLOT_W] = r_slots[k];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/id_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : id_hazard_scoreboard
// Purpose  : Decode-stage issue/stall/squash decision with per-operand
//            forwarding select, driven by an internal writer scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module id_hazard_scoreboard
    import id_hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int PIPE_DEPTH = 2,
    parameter int FWD_EN     = 1,
    parameter int LOAD_LAT   = 1,
    parameter int CNT_W      = 16,
    parameter int SEL_W      = $clog2(PIPE_DEPTH+1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] src1,
    input  logic [REG_ADDR_W-1:0] src2,
    input  logic                  src2_used,
    input  logic [REG_ADDR_W-1:0] dest,
    input  logic                  wb_en,
    input  logic                  mem_r_en,
    input  logic                  flush,
    output logic                  hazard,
    output logic                  issue,
    output logic [SEL_W-1:0]      fwd_sel1,
    output logic [SEL_W-1:0]      fwd_sel2,
    output logic [CNT_W-1:0]      stall_cnt
);

    localparam int c_SLOT_W = $bits(sb_slot_t);

    logic [PIPE_DEPTH*c_SLOT_W-1:0] w_slots_flat;
    sb_slot_t                       w_slots [PIPE_DEPTH];
    sb_slot_t                       w_shift_in;
    logic [c_SB_ADDR_W-1:0]         w_src1;
    logic [c_SB_ADDR_W-1:0]         w_src2;
    logic [PIPE_DEPTH-1:0]          w_m1;
    logic [PIPE_DEPTH-1:0]          w_m2;
    logic                           w_load_use;
    logic [SEL_W-1:0]               w_sel1;
    logic [SEL_W-1:0]               w_sel2;
    logic [CNT_W-1:0]               r_stall_cnt;

    assign w_src1 = c_SB_ADDR_W'(src1);
    assign w_src2 = c_SB_ADDR_W'(src2);

    wb_scoreboard #(
        .DEPTH      (PIPE_DEPTH)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .shift_in   (w_shift_in),
        .slots_flat (w_slots_flat)
    );

    generate
        for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_match
            assign w_slots[k] = w_slots_flat[k*c_SLOT_W +: c_SLOT_W];
            assign w_m1[k]    = sb_match(w_slots[k], w_src1, 1'b1);
            assign w_m2[k]    = sb_match(w_slots[k], w_src2, src2_used);
        end
    endgenerate

    // Scan oldest to youngest so the lowest-numbered matching slot wins.
    always_comb begin
        w_load_use = 1'b0;
        w_sel1     = SEL_W'(FWD_SEL_REGFILE);
        w_sel2     = SEL_W'(FWD_SEL_REGFILE);
        for (int k = PIPE_DEPTH-1; k >= 0; k--) begin
            if ((k < LOAD_LAT) && w_slots[k].load && (w_m1[k] || w_m2[k])) begin
                w_load_use = 1'b1;
            end
            if (w_m1[k]) begin
                w_sel1 = SEL_W'(k+1);
            end
            if (w_m2[k]) begin
                w_sel2 = SEL_W'(k+1);
            end
        end
    end

    always_comb begin
        hazard   = id_valid && ((FWD_EN != 0) ? w_load_use : |(w_m1 | w_m2));
        fwd_sel1 = (FWD_EN != 0) ? w_sel1 : SEL_W'(FWD_SEL_REGFILE);
        fwd_sel2 = (FWD_EN != 0) ? w_sel2 : SEL_W'(FWD_SEL_REGFILE);
    end

    assign issue = id_valid && !hazard && !flush;

    always_comb begin
        w_shift_in = '0;
        if (issue) begin
            w_shift_in.valid = 1'b1;
            w_shift_in.dest  = c_SB_ADDR_W'(dest);
            w_shift_in.wb_en = wb_en;
            w_shift_in.load  = mem_r_en;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (id_valid && hazard && !flush && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_id_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_hazard_scoreboard
// Purpose  : Directed vectors on three configurations (forwarding, stall-only,
//            narrow counter) with a queue-based scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_hazard_scoreboard;

    typedef struct {
        int          dut;
        logic        hz;
        logic        is;
        logic [1:0]  s1;
        logic [1:0]  s2;
        logic [15:0] cnt;
        string       name;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] v;
    logic [4:0] src1, src2, dest;
    logic       used, wb, ld, fl;

    logic [2:0]  hz, is;
    logic [1:0]  s1_a, s2_a, s1_b, s2_b, s1_c, s2_c;
    logic [15:0] cnt_a, cnt_b;
    logic [1:0]  cnt_c;

    always #5 clk = ~clk;

    id_hazard_scoreboard #(.FWD_EN(1)) u_a (
        .clk(clk), .rst(rst), .id_valid(v[0]), .src1(src1), .src2(src2),
        .src2_used(used), .dest(dest), .wb_en(wb), .mem_r_en(ld), .flush(fl),
        .hazard(hz[0]), .issue(is[0]), .fwd_sel1(s1_a), .fwd_sel2(s2_a),
        .stall_cnt(cnt_a)
    );

    id_hazard_scoreboard #(.FWD_EN(0)) u_b (
        .clk(clk), .rst(rst), .id_valid(v[1]), .src1(src1), .src2(src2),
        .src2_used(used), .dest(dest), .wb_en(wb), .mem_r_en(ld), .flush(fl),
        .hazard(hz[1]), .issue(is[1]), .fwd_sel1(s1_b), .fwd_sel2(s2_b),
        .stall_cnt(cnt_b)
    );

    id_hazard_scoreboard #(.FWD_EN(1), .CNT_W(2)) u_c (
        .clk(clk), .rst(rst), .id_valid(v[2]), .src1(src1), .src2(src2),
        .src2_used(used), .dest(dest), .wb_en(wb), .mem_r_en(ld), .flush(fl),
        .hazard(hz[2]), .issue(is[2]), .fwd_sel1(s1_c), .fwd_sel2(s2_c),
        .stall_cnt(cnt_c)
    );

    // Drive one decode cycle on DUT d and queue what it must show this cycle.
    task automatic cyc(
        input int          d,
        input logic        r,
        input logic        vv,
        input logic [4:0]  a,
        input logic [4:0]  b,
        input logic        u,
        input logic [4:0]  de,
        input logic        w,
        input logic        l,
        input logic        f,
        input logic        ehz,
        input logic        eis,
        input logic [1:0]  e1,
        input logic [1:0]  e2,
        input logic [15:0] ec,
        input string       nm
    );
        exp_t e;
        @(posedge clk);
        #1;
        rst  = r;
        v    = '0;
        v[d] = vv;
        src1 = a;
        src2 = b;
        used = u;
        dest = de;
        wb   = w;
        ld   = l;
        fl   = f;
        e.dut = d; e.hz = ehz; e.is = eis; e.s1 = e1; e.s2 = e2;
        e.cnt = ec; e.name = nm;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t        e;
            logic        a_hz, a_is;
            logic [1:0]  a_s1, a_s2;
            logic [15:0] a_cnt;
            e = q.pop_front();
            case (e.dut)
                0:       begin a_hz = hz[0]; a_is = is[0]; a_s1 = s1_a; a_s2 = s2_a; a_cnt = cnt_a; end
                1:       begin a_hz = hz[1]; a_is = is[1]; a_s1 = s1_b; a_s2 = s2_b; a_cnt = cnt_b; end
                default: begin a_hz = hz[2]; a_is = is[2]; a_s1 = s1_c; a_s2 = s2_c; a_cnt = {14'd0, cnt_c}; end
            endcase
            n_vec++;
            if (a_hz !== e.hz || a_is !== e.is || a_s1 !== e.s1 || a_s2 !== e.s2 || a_cnt !== e.cnt) begin
                n_bad++;
                $display("FAIL %s dut%0d: got hz=%b is=%b sel1=%0d sel2=%0d cnt=%0d, want hz=%b is=%b sel1=%0d sel2=%0d cnt=%0d",
                         e.name, e.dut, a_hz, a_is, a_s1, a_s2, a_cnt, e.hz, e.is, e.s1, e.s2, e.cnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; v = '0; src1 = '0; src2 = '0; used = 1'b0;
        dest = '0; wb = 1'b0; ld = 1'b0; fl = 1'b0;

        //  dut rst v  src1 src2 u dest w  l  f   hz is s1 s2 cnt
        cyc(0, 0, 1, 1,  2,  1, 3,  1, 0, 0,  0, 1, 0, 0, 0, "reset_state");
        // Forwarding config: EXE then MEM forwarding, then regfile.
        cyc(0, 1, 1, 1,  2,  1, 3,  1, 0, 0,  0, 1, 0, 0, 0, "add_r3");
        cyc(0, 1, 1, 3,  0,  1, 7,  1, 0, 0,  0, 1, 1, 0, 0, "fwd_exe");
        cyc(0, 1, 1, 3,  7,  1, 8,  1, 0, 0,  0, 1, 2, 1, 0, "fwd_mem");
        cyc(0, 1, 1, 3,  0,  1, 0,  0, 0, 0,  0, 1, 0, 0, 0, "fwd_regfile");
        // Load-use stall on src2.
        cyc(0, 1, 1, 1,  0,  0, 4,  1, 1, 0,  0, 1, 0, 0, 0, "lw_r4");
        cyc(0, 1, 1, 0,  4,  1, 9,  1, 0, 0,  1, 0, 0, 1, 0, "load_use_stall");
        cyc(0, 1, 1, 0,  4,  1, 9,  1, 0, 0,  0, 1, 0, 2, 1, "load_use_release");
        cyc(0, 1, 0, 0,  0,  0, 0,  0, 0, 0,  0, 0, 0, 0, 1, "idle");
        // Youngest writer wins; unused src2 never forwards.
        cyc(0, 1, 1, 1,  2,  1, 6,  1, 0, 0,  0, 1, 0, 0, 1, "add_r6");
        cyc(0, 1, 1, 6,  6,  0, 6,  1, 0, 0,  0, 1, 1, 0, 1, "addi_r6");
        cyc(0, 1, 1, 6,  6,  0, 10, 1, 0, 0,  0, 1, 1, 0, 1, "youngest_wins");
        // Flush during load-use: no stall counted, flushed slot becomes bubble.
        cyc(0, 1, 1, 0,  0,  0, 11, 1, 1, 0,  0, 1, 0, 0, 1, "lw_r11");
        cyc(0, 1, 1, 11, 0,  0, 12, 1, 0, 1,  1, 0, 1, 0, 1, "flush_in_stall");
        cyc(0, 1, 1, 11, 0,  0, 12, 1, 0, 0,  0, 1, 2, 0, 1, "after_flush");
        // Reset asserted mid-stall.
        cyc(0, 1, 1, 0,  0,  0, 13, 1, 1, 0,  0, 1, 0, 0, 1, "lw_r13");
        cyc(0, 1, 1, 13, 0,  0, 14, 1, 0, 0,  1, 0, 1, 0, 1, "stall_r13");
        cyc(0, 0, 1, 13, 0,  0, 14, 1, 0, 0,  0, 1, 0, 0, 0, "rst_mid_stall");
        cyc(0, 1, 0, 0,  0,  0, 0,  0, 0, 0,  0, 0, 0, 0, 0, "rst_release");

        // Stall-only config: two stall cycles, then issue with regfile source.
        cyc(1, 1, 1, 1,  2,  1, 5,  1, 0, 0,  0, 1, 0, 0, 0, "so_add_r5");
        cyc(1, 1, 1, 5,  0,  1, 15, 1, 0, 0,  1, 0, 0, 0, 0, "so_stall1");
        cyc(1, 1, 1, 5,  0,  1, 15, 1, 0, 0,  1, 0, 0, 0, 1, "so_stall2");
        cyc(1, 1, 1, 5,  0,  1, 15, 1, 0, 0,  0, 1, 0, 0, 2, "so_issue");
        cyc(1, 1, 1, 0,  0,  1, 0,  1, 0, 0,  0, 1, 0, 0, 2, "so_dest_r0");
        cyc(1, 1, 1, 0,  0,  1, 16, 1, 0, 0,  0, 1, 0, 0, 2, "so_src_r0");

        // Narrow counter: back-to-back dependent loads stall every other cycle.
        cyc(2, 1, 1, 4,  0,  0, 4,  1, 1, 0,  0, 1, 0, 0, 0, "sat_first");
        for (int i = 1; i <= 10; i++) begin
            if (i % 2 == 1) begin
                cyc(2, 1, 1, 4, 0, 0, 4, 1, 1, 0, 1, 0, 1, 0,
                    16'((((i-1)/2) > 3) ? 3 : ((i-1)/2)), "sat_stall");
            end else begin
                cyc(2, 1, 1, 4, 0, 0, 4, 1, 1, 0, 0, 1, 2, 0,
                    16'(((i/2) > 3) ? 3 : (i/2)), "sat_issue");
            end
        end

        @(posedge clk);
        #1;
        v = '0;
        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
